// File: rtl/dual_rail_pkg.sv
// Shared definitions for the dual-rail capture block: encoding names, rail codes,
// FSM states and the per-bit rail decoder.
package dual_rail_pkg;

  localparam string ENC_FP = "FP";
  localparam string ENC_TP = "TP";

  // Rail codes as {1-rail, 0-rail}; in two-phase mode they describe which rails toggled.
  localparam logic [1:0] SPACER  = 2'b00;
  localparam logic [1:0] ZERO    = 2'b01;
  localparam logic [1:0] ONE     = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    WAIT_DATA,
    CAPTURE,
    WAIT_RELEASE
  } state_e;

  function automatic logic [1:0] decode_bit(input logic       tp,
                                            input logic [1:0] rails,
                                            input logic [1:0] ref_rails);
    return tp ? (rails ^ ref_rails) : rails;
  endfunction

endpackage

// File: rtl/dual_rail_sync.sv
// Parameterised-width two-flop synchroniser with asynchronous active-high reset.
module dual_rail_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: flops use non-blocking assignments so both stages sample the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dual_rail_capture.sv
// Captures asynchronous dual-rail tokens (four-phase or two-phase), acknowledges
// upstream and delivers decoded binary words through a first-word-fall-through FIFO.
module dual_rail_capture
  import dual_rail_pkg::*;
#(
  parameter string ENC   = "FP",
  parameter int    WIDTH = 2,
  parameter int    DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0][1:0]      in,
  output logic                       ack,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     count
);

  localparam bit IS_TP = (ENC == ENC_TP);
  localparam int AW    = $clog2(DEPTH);

  logic [WIDTH-1:0][1:0] rails_q;
  logic [WIDTH-1:0][1:0] prev_q;
  logic [WIDTH-1:0][1:0] ref_q;
  logic [WIDTH-1:0][1:0] tok_q;
  logic [1:0]            warm_q;
  logic                  armed_q;
  logic                  ack_q;
  logic                  err_q;
  state_e                state_q, state_d;

  dual_rail_sync #(.W(2 * WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in),
    .q   (rails_q)
  );

  // Settling history; warm_q keeps the all-zero reset image from looking like a settled spacer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      warm_q <= '0;
    end else begin
      prev_q <= rails_q;
      warm_q <= {warm_q[0], 1'b1};
    end
  end

  logic                  all_settled;
  logic                  all_spacer;
  logic                  all_data;
  logic                  tok_illegal;
  logic [WIDTH-1:0]      cap_data;
  logic [1:0]            code_now;
  logic [1:0]            code_tok;

  always_comb begin
    all_settled = warm_q[1];
    all_spacer  = 1'b1;
    all_data    = 1'b1;
    tok_illegal = 1'b0;
    cap_data    = '0;
    code_now    = SPACER;
    code_tok    = SPACER;
    for (int i = 0; i < WIDTH; i++) begin
      code_now = decode_bit(IS_TP, rails_q[i], ref_q[i]);
      if (rails_q[i] != prev_q[i]) all_settled = 1'b0;
      if (code_now == SPACER) all_data   = 1'b0;
      else                    all_spacer = 1'b0;
      code_tok    = decode_bit(IS_TP, tok_q[i], ref_q[i]);
      cap_data[i] = (code_tok == ONE);
      if (code_tok == ILLEGAL) tok_illegal = 1'b1;
    end
  end

  logic full;
  logic push;
  logic pop;
  logic latch_tok;
  logic ref_load;
  logic err_set;
  logic ack_d;

  assign full = (count == (AW + 1)'(DEPTH));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    push      = 1'b0;
    latch_tok = 1'b0;
    ref_load  = 1'b0;
    err_set   = 1'b0;
    case (state_q)
      WAIT_DATA: begin
        if (all_settled && all_data && (IS_TP || armed_q) && !full) begin
          latch_tok = 1'b1;
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        push    = !tok_illegal;
        err_set = tok_illegal;
        ack_d   = IS_TP ? ~ack_q : 1'b1;
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (IS_TP) begin
          ref_load = 1'b1;
          state_d  = WAIT_DATA;
        end else if (all_settled && all_spacer) begin
          ack_d   = 1'b0;
          state_d = WAIT_DATA;
        end
      end
      default: state_d = WAIT_DATA;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_DATA;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
      tok_q   <= '0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      if (err_set) err_q <= 1'b1;
      // Four-phase capture is only armed once a clean spacer has been seen after reset.
      if (all_settled && all_spacer) armed_q <= 1'b1;
      if (latch_tok) tok_q <= rails_q;
      if (ref_load) ref_q <= tok_q;
    end
  end

  assign ack = ack_q;
  assign err = err_q;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // NOTE: storage is not reset; out_data is gated by out_valid so stale words never show.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cap_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_rail_capture.sv
// Directed scoreboard bench for dual_rail_capture: one four-phase and one two-phase instance.
module tb_dual_rail_capture;
  import dual_rail_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0][1:0] fp_in, tp_in;
  logic            fp_ack, tp_ack, fp_valid, tp_valid, fp_err, tp_err;
  logic            fp_ready, tp_ready;
  logic [1:0]      fp_data, tp_data;
  logic [2:0]      fp_count, tp_count;

  int checks   = 0;
  int failures = 0;
  logic [1:0] fp_q[$];
  logic [1:0] tp_q[$];

  always #5 clk = ~clk;

  dual_rail_capture #(.ENC("FP"), .WIDTH(2), .DEPTH(4)) u_fp (
    .clk(clk), .rst(rst), .in(fp_in), .ack(fp_ack), .out_data(fp_data),
    .out_valid(fp_valid), .out_ready(fp_ready), .err(fp_err), .count(fp_count)
  );

  dual_rail_capture #(.ENC("TP"), .WIDTH(2), .DEPTH(4)) u_tp (
    .clk(clk), .rst(rst), .in(tp_in), .ack(tp_ack), .out_data(tp_data),
    .out_valid(tp_valid), .out_ready(tp_ready), .err(tp_err), .count(tp_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fp_drive(input logic [1:0] v);
    for (int i = 0; i < 2; i++) fp_in[i] = v[i] ? ONE : ZERO;
  endtask

  task automatic wait_fp_ack(input logic exp, input string tag);
    int n = 0;
    while (fp_ack !== exp && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, fp_ack, exp);
  endtask

  task automatic wait_tp_ack(input logic exp, input string tag);
    int n = 0;
    while (tp_ack !== exp && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, tp_ack, exp);
  endtask

  task automatic fp_handshake(input logic [1:0] v, input string tag);
    fp_drive(v);
    fp_q.push_back(v);
    wait_fp_ack(1'b1, tag);
    fp_in = '0;
    wait_fp_ack(1'b0, tag);
  endtask

  task automatic fp_pop(input string tag);
    logic [1:0] exp;
    exp = (fp_q.size() != 0) ? fp_q.pop_front() : 2'bxx;
    check(tag, fp_valid, 1'b1);
    check(tag, fp_data, exp);
    fp_ready = 1'b1;
    @(negedge clk);
    fp_ready = 1'b0;
  endtask

  task automatic tp_pop(input string tag);
    logic [1:0] exp;
    exp = (tp_q.size() != 0) ? tp_q.pop_front() : 2'bxx;
    check(tag, tp_valid, 1'b1);
    check(tag, tp_data, exp);
    tp_ready = 1'b1;
    @(negedge clk);
    tp_ready = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    fp_in    = '0;
    tp_in    = '0;
    fp_ready = 1'b0;
    tp_ready = 1'b0;
    cyc(3);
    check("reset_ack", fp_ack, 1'b0);
    check("reset_valid", fp_valid, 1'b0);
    check("reset_data", fp_data, 2'b00);
    check("reset_err", fp_err, 1'b0);
    check("reset_count", fp_count, 3'd0);
    check("reset_tp_ack", tp_ack, 1'b0);
    rst = 1'b0;
    cyc(5);

    // Full token 11: push latency, ack rise, ack fall after spacer.
    fp_drive(2'b11);
    fp_q.push_back(2'b11);
    cyc(4);
    check("latency_edge4_valid", fp_valid, 1'b0);
    cyc(1);
    check("latency_edge5_valid", fp_valid, 1'b1);
    check("latency_edge5_ack", fp_ack, 1'b1);
    fp_in = '0;
    wait_fp_ack(1'b0, "spacer_ack_fall");
    fp_pop("pop_11");
    check("count_after_pop", fp_count, 3'd0);

    // Partial token must not be captured.
    fp_in[0] = ONE;
    fp_in[1] = SPACER;
    cyc(12);
    check("partial_count", fp_count, 3'd0);
    check("partial_ack", fp_ack, 1'b0);
    fp_in[1] = ZERO;
    fp_q.push_back(2'b01);
    wait_fp_ack(1'b1, "partial_done_ack");
    fp_in = '0;
    wait_fp_ack(1'b0, "partial_release");
    fp_pop("pop_01");

    // Illegal code: err set, nothing pushed, handshake still completes.
    fp_in[0] = ILLEGAL;
    fp_in[1] = ONE;
    wait_fp_ack(1'b1, "illegal_ack");
    check("illegal_err", fp_err, 1'b1);
    check("illegal_count", fp_count, 3'd0);
    fp_in = '0;
    wait_fp_ack(1'b0, "illegal_release");
    fp_handshake(2'b10, "after_illegal");
    check("err_sticky", fp_err, 1'b1);
    fp_pop("pop_after_illegal");

    // Backpressure: four tokens fill the FIFO, fifth ack withheld until a pop.
    for (int i = 0; i < 4; i++) fp_handshake(2'(i), "fill");
    check("full_count", fp_count, 3'd4);
    fp_drive(2'b00);
    fp_q.push_back(2'b00);
    cyc(20);
    check("full_ack_withheld", fp_ack, 1'b0);
    check("full_count_hold", fp_count, 3'd4);
    fp_pop("bp_pop0");
    wait_fp_ack(1'b1, "fifth_ack");
    check("fifth_count", fp_count, 3'd4);
    fp_in = '0;
    wait_fp_ack(1'b0, "fifth_release");
    for (int i = 0; i < 4; i++) fp_pop("bp_order");
    check("drained_count", fp_count, 3'd0);

    // Reset in WAIT_RELEASE with two words queued.
    fp_handshake(2'b01, "pre_reset1");
    fp_drive(2'b10);
    fp_q.push_back(2'b10);
    wait_fp_ack(1'b1, "pre_reset2_ack");
    check("pre_reset_count", fp_count, 3'd2);
    rst = 1'b1;
    #2;
    check("midrst_ack", fp_ack, 1'b0);
    check("midrst_valid", fp_valid, 1'b0);
    check("midrst_data", fp_data, 2'b00);
    check("midrst_err", fp_err, 1'b0);
    check("midrst_count", fp_count, 3'd0);
    fp_q.delete();
    tp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    cyc(15);
    check("post_rst_no_capture", fp_count, 3'd0);
    check("post_rst_ack", fp_ack, 1'b0);
    fp_in = '0;
    cyc(5);
    fp_handshake(2'b11, "post_rst_hs");
    fp_pop("post_rst_pop");

    // Two-phase: 0-rails toggle (00), then bit0 0-rail and bit1 1-rail toggle (10).
    tp_in[0][0] = ~tp_in[0][0];
    tp_in[1][0] = ~tp_in[1][0];
    tp_q.push_back(2'b00);
    wait_tp_ack(1'b1, "tp_ack_toggle1");
    tp_pop("tp_pop_00");
    cyc(2);
    tp_in[0][0] = ~tp_in[0][0];
    tp_in[1][1] = ~tp_in[1][1];
    tp_q.push_back(2'b10);
    wait_tp_ack(1'b0, "tp_ack_toggle2");
    tp_pop("tp_pop_10");
    check("tp_err", tp_err, 1'b0);
    check("tp_count", tp_count, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_rail_capture.md
DUAL_RAIL_CAPTURE -- requirements
Module: dual_rail_capture

Interface
REQ-001 SHALL have parameter ENC, default "FP", rail encoding: "FP" four-phase return-to-zero, "TP" two-phase transition.
REQ-002 SHALL have parameter WIDTH, default 2, number of dual-rail bits per token (full-adder {c_out,s}).
REQ-003 SHALL have parameter DEPTH, default 4, output FIFO entries, power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, sole clock; every flop is on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port in, input, [WIDTH-1:0][1:0], asynchronous dual-rail token from upstream; [1] is the 1-rail, [0] is the 0-rail.
REQ-007 SHALL have port ack, output, 1, acknowledge to upstream.
REQ-008 SHALL have port out_data, output, WIDTH, decoded binary token at the FIFO head.
REQ-009 SHALL have port out_valid, output, 1, FIFO non-empty.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts out_data.
REQ-011 SHALL have port err, output, 1, sticky illegal-code flag.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1, FIFO occupancy.

Function
REQ-013 SHALL synchronise every rail of in through two flops before any use.
REQ-014 SHALL treat a bit as settled only when its synchronised rails are equal on two consecutive cycles.
REQ-015 SHALL decode in FP as follows: 01 is 0, 10 is 1, 00 is spacer, 11 is illegal.
REQ-016 SHALL decode in TP against the rails of the last accepted token: only [0] toggled is 0, only [1] toggled is 1, neither toggled is no data, both toggled is illegal.
REQ-017 SHALL implement the FSM states WAIT_DATA, CAPTURE and WAIT_RELEASE.
REQ-018 SHALL move WAIT_DATA to CAPTURE only when all WIDTH bits are settled and non-spacer; partial tokens keep the FSM in WAIT_DATA.
REQ-019 SHALL make CAPTURE last exactly one cycle: push the decoded token, set ack (FP) or toggle ack (TP), then go to WAIT_RELEASE.
REQ-020 SHALL, in FP, leave WAIT_RELEASE when all bits are settled spacer: clear ack, return to WAIT_DATA.
REQ-021 SHALL, in TP, leave WAIT_RELEASE after one cycle, updating the reference rails to the captured values.
REQ-022 SHALL hold the FSM in WAIT_DATA with ack unchanged while FIFO count equals DEPTH, giving backpressure to upstream.
REQ-023 SHALL, when any bit decodes illegal in a settled complete token: set err, discard the token (no push), and still complete the ack handshake.
REQ-024 SHALL push the token on the 4th rising clk edge after the last rail edge meets setup; out_valid rises on the following edge.
REQ-025 SHALL pop on out_valid and out_ready; a simultaneous push and pop leaves count unchanged; a pop when empty is ignored.
REQ-026 SHALL give first-word-fall-through out_data, with pointers wrapping modulo DEPTH.

Reset
REQ-027 SHALL, while rst is high: ack=0, out_valid=0, out_data=0, err=0, count=0, FSM in WAIT_DATA, synchronisers and TP reference rails cleared to 0.
REQ-028 SHALL, on rst mid-handshake, flush the FIFO and drop the in-flight token; after release, FP waits for spacer before any capture.

Structure
REQ-029 SHALL place the following in shared package dual_rail_pkg: the ENC string constants, the rail code localparams (SPACER, ZERO, ONE, ILLEGAL), the FSM state enum and a per-bit decode function.
REQ-030 SHALL instantiate a single sub-module dual_rail_sync (parameterised-width two-flop synchroniser, async-reset).
REQ-031 SHALL implement the FIFO inline.

Verification
REQ-032 SHALL cover: FP, in={10,10} held, then 00 -> out_data=2'b11 four cycles later; ack rises, then falls after spacer.
REQ-033 SHALL cover: FP, in={01,10} then one bit held at 00 -> no push until the second bit settles, then out_data=2'b01.
REQ-034 SHALL cover: FP, one bit =11 -> err=1, count unchanged, ack still cycles; a legal token afterwards is captured, err stays 1.
REQ-035 SHALL cover: out_ready=0 with 5 tokens -> count=4, 5th ack withheld; one pop -> 5th captured, order 0..4 preserved.
REQ-036 SHALL cover: TP, 0-rail toggles on bit0 then 1-rail toggles on bit1 in the next token -> ack toggles twice, out_data=2'b00 then 2'b10.
REQ-037 SHALL cover: rst pulsed during WAIT_RELEASE with count=2 -> all outputs 0, next full FP handshake is captured normally.
